// File: rtl/icache_tagstat_stage.sv
// Instruction-cache tag/status stage: flop-based tag and status arrays with a
// registered one-cycle lookup, write-first forwarding and a flash-invalidate sweep.
module icache_tagstat_stage #(
  parameter int NUM_WAYS       = 4,
  parameter int SET_BITS_WIDTH = 4,
  parameter int TAG_WIDTH      = 8,
  parameter int STATUS_WIDTH   = 2,
  parameter int METADATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             i_halt,
  input  logic [METADATA_WIDTH-1:0]        i_metadata,
  input  logic                             i_metadata_valid,
  input  logic [SET_BITS_WIDTH-1:0]        i_r_set_addr,
  input  logic                             i_r_valid,
  input  logic [SET_BITS_WIDTH-1:0]        i_w_ta_set_addr,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0]    i_w_ta_data,
  input  logic [NUM_WAYS-1:0]              i_w_ta_mask,
  input  logic                             i_w_ta_valid,
  input  logic [SET_BITS_WIDTH-1:0]        i_w_sa_set_addr,
  input  logic [NUM_WAYS*STATUS_WIDTH-1:0] i_w_sa_data,
  input  logic [NUM_WAYS-1:0]              i_w_sa_mask,
  input  logic                             i_w_sa_valid,
  input  logic                             i_inval_all,
  output logic [NUM_WAYS*TAG_WIDTH-1:0]    o_ta_data,
  output logic                             o_ta_data_valid,
  output logic [NUM_WAYS*STATUS_WIDTH-1:0] o_sa_data,
  output logic                             o_sa_data_valid,
  output logic [METADATA_WIDTH-1:0]        o_metadata,
  output logic                             o_metadata_valid,
  output logic                             o_inval_busy,
  output logic                             o_ready
);

  localparam int NUM_SETS = 1 << SET_BITS_WIDTH;
  localparam int TA_W     = NUM_WAYS * TAG_WIDTH;
  localparam int SA_W     = NUM_WAYS * STATUS_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                    state;
  logic [SET_BITS_WIDTH-1:0] sweep_cnt;

  logic [TA_W-1:0] tag_mem  [NUM_SETS];
  logic [SA_W-1:0] stat_mem [NUM_SETS];

  logic            r_acc;
  logic            ta_acc;
  logic            sa_acc;
  logic            md_acc;
  logic [TA_W-1:0] rd_ta;
  logic [SA_W-1:0] rd_sa;

  // Handshake: every valid (reads, writes, metadata, i_inval_all) is consumed
  // on an edge where o_ready=1; with o_ready=0 it is dropped, except that
  // i_halt freezes the whole stage so nothing advances or is lost.
  assign o_ready      = (state == IDLE) && !i_halt;
  assign o_inval_busy = (state == SWEEP);

  assign r_acc  = o_ready && i_r_valid;
  assign ta_acc = o_ready && i_w_ta_valid;
  assign sa_acc = o_ready && i_w_sa_valid;
  assign md_acc = o_ready && i_metadata_valid;

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
    end else if (!i_halt) begin
      case (state)
        IDLE: begin
          if (i_inval_all) state <= SWEEP;
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == '1) state <= IDLE;
        end
        default: state <= SWEEP;
      endcase
    end
  end

  // Sweep and accepted writes never coincide: writes need state IDLE.
  always_ff @(posedge clk) begin
    if (!srst && !i_halt) begin
      if (state == SWEEP) stat_mem[sweep_cnt] <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (ta_acc && i_w_ta_mask[w])
          tag_mem[i_w_ta_set_addr][w*TAG_WIDTH +: TAG_WIDTH] <=
            i_w_ta_data[w*TAG_WIDTH +: TAG_WIDTH];
        if (sa_acc && i_w_sa_mask[w])
          stat_mem[i_w_sa_set_addr][w*STATUS_WIDTH +: STATUS_WIDTH] <=
            i_w_sa_data[w*STATUS_WIDTH +: STATUS_WIDTH];
      end
    end
  end

  // Write-first: a same-cycle write to the looked-up set overrides its ways.
  always_comb begin
    rd_ta = tag_mem[i_r_set_addr];
    rd_sa = stat_mem[i_r_set_addr];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ta_acc && i_w_ta_mask[w] && (i_w_ta_set_addr == i_r_set_addr))
        rd_ta[w*TAG_WIDTH +: TAG_WIDTH] = i_w_ta_data[w*TAG_WIDTH +: TAG_WIDTH];
      if (sa_acc && i_w_sa_mask[w] && (i_w_sa_set_addr == i_r_set_addr))
        rd_sa[w*STATUS_WIDTH +: STATUS_WIDTH] = i_w_sa_data[w*STATUS_WIDTH +: STATUS_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      o_ta_data        <= '0;
      o_ta_data_valid  <= 1'b0;
      o_sa_data        <= '0;
      o_sa_data_valid  <= 1'b0;
      o_metadata       <= '0;
      o_metadata_valid <= 1'b0;
    end else if (!i_halt) begin
      o_ta_data_valid  <= r_acc;
      o_sa_data_valid  <= r_acc;
      o_metadata_valid <= md_acc;
      if (r_acc) begin
        o_ta_data <= rd_ta;
        o_sa_data <= rd_sa;
      end
      if (md_acc) o_metadata <= i_metadata;
    end
  end

endmodule

// File: tb/tb_icache_tagstat_stage.sv
// Bench for icache_tagstat_stage: directed scenarios followed by random traffic,
// every cycle compared against an apply-writes-then-read array model.
module tb_icache_tagstat_stage;

  localparam int NW = 4;
  localparam int SB = 4;
  localparam int TW = 8;
  localparam int SW = 2;
  localparam int MW = 16;
  localparam int NS = 16;

  logic              clk;
  logic              srst;
  logic              i_halt;
  logic [MW-1:0]     i_metadata;
  logic              i_metadata_valid;
  logic [SB-1:0]     i_r_set_addr;
  logic              i_r_valid;
  logic [SB-1:0]     i_w_ta_set_addr;
  logic [NW*TW-1:0]  i_w_ta_data;
  logic [NW-1:0]     i_w_ta_mask;
  logic              i_w_ta_valid;
  logic [SB-1:0]     i_w_sa_set_addr;
  logic [NW*SW-1:0]  i_w_sa_data;
  logic [NW-1:0]     i_w_sa_mask;
  logic              i_w_sa_valid;
  logic              i_inval_all;
  logic [NW*TW-1:0]  o_ta_data;
  logic              o_ta_data_valid;
  logic [NW*SW-1:0]  o_sa_data;
  logic              o_sa_data_valid;
  logic [MW-1:0]     o_metadata;
  logic              o_metadata_valid;
  logic              o_inval_busy;
  logic              o_ready;

  icache_tagstat_stage dut (
    .clk(clk), .srst(srst), .i_halt(i_halt),
    .i_metadata(i_metadata), .i_metadata_valid(i_metadata_valid),
    .i_r_set_addr(i_r_set_addr), .i_r_valid(i_r_valid),
    .i_w_ta_set_addr(i_w_ta_set_addr), .i_w_ta_data(i_w_ta_data),
    .i_w_ta_mask(i_w_ta_mask), .i_w_ta_valid(i_w_ta_valid),
    .i_w_sa_set_addr(i_w_sa_set_addr), .i_w_sa_data(i_w_sa_data),
    .i_w_sa_mask(i_w_sa_mask), .i_w_sa_valid(i_w_sa_valid),
    .i_inval_all(i_inval_all),
    .o_ta_data(o_ta_data), .o_ta_data_valid(o_ta_data_valid),
    .o_sa_data(o_sa_data), .o_sa_data_valid(o_sa_data_valid),
    .o_metadata(o_metadata), .o_metadata_valid(o_metadata_valid),
    .o_inval_busy(o_inval_busy), .o_ready(o_ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // reference model: plain per-way arrays plus a "sweep still running" flag
  bit          m_busy;
  int          m_left;
  logic [7:0]  tag_m [NS][NW];
  logic [1:0]  st_m  [NS][NW];
  logic [31:0] e_ta;
  logic [7:0]  e_sa;
  logic        e_v;
  logic [15:0] e_md;
  logic        e_mdv;
  int          m_next_clear;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic idle_inputs();
    srst = 1'b0; i_halt = 1'b0; i_inval_all = 1'b0;
    i_metadata = '0; i_metadata_valid = 1'b0;
    i_r_set_addr = '0; i_r_valid = 1'b0;
    i_w_ta_set_addr = '0; i_w_ta_data = '0; i_w_ta_mask = '0; i_w_ta_valid = 1'b0;
    i_w_sa_set_addr = '0; i_w_sa_data = '0; i_w_sa_mask = '0; i_w_sa_valid = 1'b0;
  endtask

  // advance the model with the inputs currently applied, clock, then compare
  task automatic tick();
    if (srst) begin
      m_busy = 1'b1; m_next_clear = 0;
      e_ta = '0; e_sa = '0; e_v = 1'b0; e_md = '0; e_mdv = 1'b0;
    end else if (!i_halt) begin
      if (m_busy) begin
        for (int w = 0; w < NW; w++) st_m[m_next_clear][w] = 2'b00;
        m_next_clear++;
        if (m_next_clear == NS) begin
          m_busy = 1'b0;
          m_next_clear = 0;
        end
        e_v = 1'b0; e_mdv = 1'b0;
      end else begin
        if (i_w_ta_valid)
          for (int w = 0; w < NW; w++)
            if (i_w_ta_mask[w]) tag_m[i_w_ta_set_addr][w] = i_w_ta_data[w*TW +: TW];
        if (i_w_sa_valid)
          for (int w = 0; w < NW; w++)
            if (i_w_sa_mask[w]) st_m[i_w_sa_set_addr][w] = i_w_sa_data[w*SW +: SW];
        if (i_r_valid)
          for (int w = 0; w < NW; w++) begin
            e_ta[w*TW +: TW] = tag_m[i_r_set_addr][w];
            e_sa[w*SW +: SW] = st_m[i_r_set_addr][w];
          end
        e_v = i_r_valid;
        e_mdv = i_metadata_valid;
        if (i_metadata_valid) e_md = i_metadata;
        if (i_inval_all) m_busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("ta_data", 64'(o_ta_data), 64'(e_ta));
    chk("sa_data", 64'(o_sa_data), 64'(e_sa));
    chk("ta_valid", 64'(o_ta_data_valid), 64'(e_v));
    chk("sa_valid", 64'(o_sa_data_valid), 64'(e_v));
    chk("metadata", 64'(o_metadata), 64'(e_md));
    chk("md_valid", 64'(o_metadata_valid), 64'(e_mdv));
    chk("inval_busy", 64'(o_inval_busy), 64'(m_busy));
    chk("ready", 64'(o_ready), 64'(!m_busy && !i_halt));
  endtask

  task automatic count_until_ready(output int n);
    n = 0;
    while (!o_ready && n < 40) begin
      i_r_set_addr = 4'($urandom_range(0, NS-1));
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    m_busy = 1'b1; m_next_clear = 0;
    e_ta = '0; e_sa = '0; e_v = 1'b0; e_md = '0; e_mdv = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        tag_m[s][w] = '0;
        st_m[s][w] = '0;
      end

    // reset release: reads and status writes offered during the sweep are refused
    srst = 1'b1;
    repeat (3) tick();
    srst = 1'b0;
    i_r_valid = 1'b1;
    i_w_sa_valid = 1'b1; i_w_sa_data = 8'hFF; i_w_sa_mask = 4'hF; i_w_sa_set_addr = 4'd2;
    count_until_ready(n);
    chk("reset_sweep_edges", 64'(n), 64'd16);
    idle_inputs();

    // give every tag a known value, then confirm all status reads zero
    for (int s = 0; s < NS; s++) begin
      i_w_ta_valid = 1'b1; i_w_ta_set_addr = 4'(s); i_w_ta_mask = 4'hF;
      i_w_ta_data = $urandom;
      tick();
    end
    idle_inputs();
    for (int s = 0; s < NS; s++) begin
      i_r_valid = 1'b1; i_r_set_addr = 4'(s);
      tick();
      chk("post_reset_sa_zero", 64'(o_sa_data), 64'd0);
    end
    idle_inputs();

    // write then read set 5
    i_w_ta_valid = 1'b1; i_w_ta_set_addr = 4'd5; i_w_ta_mask = 4'hF; i_w_ta_data = 32'hDDCCBBAA;
    tick();
    idle_inputs();
    i_r_valid = 1'b1; i_r_set_addr = 4'd5; i_metadata_valid = 1'b1; i_metadata = 16'hBEEF;
    tick();
    chk("wr_rd_set5", 64'(o_ta_data), 64'h0DDCCBBAA);
    chk("wr_rd_md", 64'(o_metadata), 64'hBEEF);

    // same-cycle forwarding on set 3
    idle_inputs();
    i_w_ta_valid = 1'b1; i_w_ta_set_addr = 4'd3; i_w_ta_mask = 4'hF; i_w_ta_data = 32'h44332211;
    tick();
    i_w_ta_mask = 4'b0100; i_w_ta_data = 32'h00EE0000;
    i_r_valid = 1'b1; i_r_set_addr = 4'd3;
    tick();
    chk("forward_set3", 64'(o_ta_data), 64'h44EE2211);

    // halt for 3 cycles with a valid lookup on the outputs and writes offered
    idle_inputs();
    i_r_valid = 1'b1; i_r_set_addr = 4'd5;
    tick();
    i_halt = 1'b1; i_r_set_addr = 4'd3;
    i_w_ta_valid = 1'b1; i_w_ta_set_addr = 4'd5; i_w_ta_mask = 4'hF; i_w_ta_data = 32'h0;
    i_inval_all = 1'b1;
    repeat (3) begin
      tick();
      chk("halt_frozen_ta", 64'(o_ta_data), 64'h0DDCCBBAA);
      chk("halt_not_ready", 64'(o_ready), 64'd0);
    end
    idle_inputs();
    i_r_valid = 1'b1; i_r_set_addr = 4'd5;
    tick();
    chk("halt_array_kept", 64'(o_ta_data), 64'h0DDCCBBAA);

    // fill status, then flash-invalidate
    idle_inputs();
    for (int s = 0; s < NS; s++) begin
      i_w_sa_valid = 1'b1; i_w_sa_set_addr = 4'(s); i_w_sa_mask = 4'hF; i_w_sa_data = 8'hFF;
      tick();
    end
    idle_inputs();
    i_r_valid = 1'b1; i_r_set_addr = 4'd7;
    tick();
    chk("filled_sa", 64'(o_sa_data), 64'hFF);
    i_r_valid = 1'b0; i_inval_all = 1'b1;
    tick();
    i_inval_all = 1'b0; i_r_valid = 1'b1;
    n = 0;
    while (o_inval_busy && n < 40) begin
      tick();
      n++;
    end
    chk("inval_busy_cycles", 64'(n), 64'd16);
    for (int s = 0; s < NS; s++) begin
      i_r_valid = 1'b1; i_r_set_addr = 4'(s);
      tick();
      chk("post_inval_sa_zero", 64'(o_sa_data), 64'd0);
    end

    // srst landing while the sweep sits at set 9
    idle_inputs();
    for (int s = 0; s < NS; s++) begin
      i_w_sa_valid = 1'b1; i_w_sa_set_addr = 4'(s); i_w_sa_mask = 4'hF; i_w_sa_data = 8'hAA;
      tick();
    end
    idle_inputs();
    i_inval_all = 1'b1;
    tick();
    i_inval_all = 1'b0;
    repeat (9) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    count_until_ready(n);
    chk("srst_restart_edges", 64'(n), 64'd16);
    i_r_valid = 1'b1; i_r_set_addr = 4'd12;
    tick();
    chk("srst_restart_sa", 64'(o_sa_data), 64'd0);

    // random traffic, writes often aimed at the looked-up set
    for (int i = 0; i < 400; i++) begin
      srst = ($urandom_range(0, 299) == 0);
      i_halt = ($urandom_range(0, 7) == 0);
      i_inval_all = ($urandom_range(0, 59) == 0);
      i_r_valid = 1'($urandom_range(0, 1));
      i_r_set_addr = 4'($urandom_range(0, NS-1));
      i_metadata_valid = 1'($urandom_range(0, 1));
      i_metadata = 16'($urandom);
      i_w_ta_valid = 1'($urandom_range(0, 1));
      i_w_ta_set_addr = $urandom_range(0, 1) ? i_r_set_addr : 4'($urandom_range(0, NS-1));
      i_w_ta_data = $urandom;
      i_w_ta_mask = 4'($urandom_range(0, 15));
      i_w_sa_valid = 1'($urandom_range(0, 1));
      i_w_sa_set_addr = $urandom_range(0, 1) ? i_r_set_addr : 4'($urandom_range(0, NS-1));
      i_w_sa_data = 8'($urandom);
      i_w_sa_mask = 4'($urandom_range(0, 15));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/icache_tagstat_stage.md
# icache_tagstat_stage

Parametrised successor of the instruction-cache first stage. It holds the tag array and status array for an N-way, 2^SET_BITS_WIDTH-set cache in internal flop storage. It performs a registered one-cycle lookup of all ways of the addressed set, with same-cycle write-to-read forwarding. It also provides a built-in flash-invalidate sequencer that clears every set's status at reset or on request. It sits between the fetch-address stage and the hit/way-select stage, and carries request metadata alongside the lookup.

## Interface
- NUM_WAYS, 4, associativity; also width of the per-way write masks
- SET_BITS_WIDTH, 4, set index width; NUM_SETS = 2^SET_BITS_WIDTH
- TAG_WIDTH, 8, tag bits per way
- STATUS_WIDTH, 2, status bits per way; all-zero means invalid
- METADATA_WIDTH, 16, width of the pass-through request metadata
- clk  in  1  single clock, rising edge
- srst  in  1  reset, synchronous, active-high
- i_halt  in  1  stall; freezes all state and holds all outputs
- i_metadata / i_metadata_valid  in  METADATA_WIDTH / 1  request metadata
- i_r_set_addr / i_r_valid  in  SET_BITS_WIDTH / 1  lookup request
- i_w_ta_set_addr, i_w_ta_data, i_w_ta_mask, i_w_ta_valid  in  SET_BITS_WIDTH, NUM_WAYS*TAG_WIDTH, NUM_WAYS, 1  tag write; way w occupies bits [w*TAG_WIDTH +: TAG_WIDTH]
- i_w_sa_set_addr, i_w_sa_data, i_w_sa_mask, i_w_sa_valid  in  SET_BITS_WIDTH, NUM_WAYS*STATUS_WIDTH, NUM_WAYS, 1  status write; same packing
- i_inval_all  in  1  request a flash-invalidate of all status entries
- o_ta_data / o_ta_data_valid  out  NUM_WAYS*TAG_WIDTH / 1  lookup tags
- o_sa_data / o_sa_data_valid  out  NUM_WAYS*STATUS_WIDTH / 1  lookup status
- o_metadata / o_metadata_valid  out  METADATA_WIDTH / 1  registered metadata
- o_inval_busy  out  1  invalidate sweep in progress
- o_ready  out  1  inputs are accepted this cycle

## Operation
- The FSM has two states, IDLE and SWEEP. There is a sweep counter of SET_BITS_WIDTH bits.
- srst high: state=SWEEP and counter=0. All output data and valids are 0.
- SWEEP, not halted, srst low:
  - Every way's status in set[counter] is written to 0. The counter increments.
  - When counter == NUM_SETS-1, the set is cleared and the FSM moves to IDLE. The counter wraps to 0.
- IDLE with i_inval_all=1 and not halted: the FSM moves to SWEEP next cycle. Reads and writes in that same cycle are still accepted.
- Tag contents are never cleared; they are don't-care wherever status is 0.
- o_ready = (state==IDLE) & ~i_halt, combinational.
- Valids, writes and i_inval_all are honoured only when o_ready=1. Otherwise they are ignored. i_halt is the exception: it holds state instead of dropping anything.
- Write, when accepted: ways with mask bit 1 in the addressed set are updated at the clock edge. Masked-off ways are unchanged. Tag and status writes are independent and may target different sets in the same cycle.
- Read, when accepted: the next-cycle outputs are the addressed set's contents, with write-first forwarding. In any way where a same-cycle accepted write hits the same set with mask=1, the new data is returned.
- Metadata is registered in the same cycle as the lookup: o_metadata_valid = i_metadata_valid & o_ready.
- o_ta_data_valid = o_sa_data_valid = accepted i_r_valid, registered.
- Cycles with no accepted read: the output valids drop to 0. The data outputs hold their last value.
- i_halt=1: the array, FSM, counter and every output register hold their values.

## Timing
- Lookup latency is 1 cycle from the accepting edge to the output valids.
- Reset values: all o_* data = 0 and all o_* valids = 0. o_ready = 0. o_inval_busy = 1 (state SWEEP).
- Sweep duration: set k is cleared on the (k+1)-th un-halted edge after srst falls. o_ready rises after the NUM_SETS-th such edge (16 edges at defaults).
- o_inval_busy = (state==SWEEP), registered-state decode.
- srst asserted mid-sweep or mid-lookup: the sweep restarts from set 0 and output valids clear on that edge.
- i_inval_all during SWEEP is ignored; no sweep is queued.

## Test plan
- Reset release: count edges until o_ready=1 -> exactly 16 at defaults. Every output valid is 0 throughout the sweep, and a read of any set returns o_sa_data=0.
- Write then read: write set 5 with tag data 0xDDCCBBAA and mask 4'b1111, then read set 5 on the next cycle -> o_ta_data=0xDDCCBBAA with valid high 1 cycle later.
- Forwarding: set 3 holds 0x44332211; a same-cycle read and tag write of set 3 with mask 4'b0100 and data 0x00EE0000 -> o_ta_data=0x44EE2211.
- Halt: assert i_halt for 3 cycles while o_ta_data_valid=1 -> outputs frozen, o_ready=0, and the array is unchanged by any writes presented during the halt.
- Invalidate: fill every set's status with 2'b11, then pulse i_inval_all -> o_inval_busy high for 16 cycles with reads refused, and afterwards every set reads o_sa_data=0.
- srst pulsed at sweep set 9 -> the sweep restarts from set 0, with o_ready low for a further 16 edges.
